// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// The round-robin pointer encodes which requester won the most recent grant.
package rf_pkg;

  localparam int DW = 16;
  localparam int AW = 4;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic {
    LAST_A = REQ_A,
    LAST_B = REQ_B
  } rr_ptr_t;

  // Round-robin choice when both requesters are valid: favour the one that did not win last.
  function automatic logic pick_b(input rr_ptr_t last);
    return (last == LAST_A);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with its pointer register.
// Grants are combinational from the requests; the pointer moves only on a grant.
module rr_arb2
  import rf_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  logic    req_a,
  input  logic    req_b,
  output logic    gnt_a,
  output logic    gnt_b,
  output rr_ptr_t last
);

  rr_ptr_t ptr;
  rr_ptr_t ptr_next;

  // Pointer register; reset prefers A on the first contention.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= LAST_B;
    end else begin
      ptr <= ptr_next;
    end
  end

  // Grant selection and pointer update.
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    ptr_next = ptr;
    if (en) begin
      case ({req_a, req_b})
        2'b10: gnt_a = 1'b1;
        2'b01: gnt_b = 1'b1;
        2'b11: begin
          if (pick_b(ptr)) begin
            gnt_b = 1'b1;
          end else begin
            gnt_a = 1'b1;
          end
        end
        default: begin
          gnt_a = 1'b0;
          gnt_b = 1'b0;
        end
      endcase
    end else begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
    if (gnt_a) begin
      ptr_next = LAST_A;
    end else if (gnt_b) begin
      ptr_next = LAST_B;
    end else begin
      ptr_next = ptr;
    end
  end

  assign last = ptr;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter sharing the register file's single write port between
// the ALU (A) and load unit (B), with a registered write stage.
module rf_wb_arbiter #(
  parameter int DW = rf_pkg::DW,
  parameter int AW = rf_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_stall,
  input  logic          a_valid,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          rf_wr,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_wdata,
  output logic          last_grant
);
  import rf_pkg::*;

  logic    arb_en;
  logic    gnt_a;
  logic    gnt_b;
  rr_ptr_t ptr;

  // Holding reset also blocks grants, so nothing is accepted while in reset.
  assign arb_en = rst & ~wb_stall;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .last  (ptr)
  );

  assign a_ready    = gnt_a;
  assign b_ready    = gnt_b;
  assign last_grant = (ptr == LAST_B);

  // Write stage: capture the winner; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_wr    <= 1'b0;
      rf_rd    <= {AW{1'b0}};
      rf_wdata <= {DW{1'b0}};
    end else if (gnt_a) begin
      rf_wr    <= 1'b1;
      rf_rd    <= a_rd;
      rf_wdata <= a_data;
    end else if (gnt_b) begin
      rf_wr    <= 1'b1;
      rf_rd    <= b_rd;
      rf_wdata <= b_data;
    end else begin
      rf_wr    <= 1'b0;
      rf_rd    <= rf_rd;
      rf_wdata <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter with a behavioural register file.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_stall;
  logic        a_valid;
  logic [3:0]  a_rd;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [3:0]  b_rd;
  logic [15:0] b_data;
  logic        b_ready;
  logic        rf_wr;
  logic [3:0]  rf_rd;
  logic [15:0] rf_wdata;
  logic        last_grant;

  logic [15:0] mem [16];

  int passed = 0;
  int total  = 0;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .wb_stall   (wb_stall),
    .a_valid    (a_valid),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .rf_wr      (rf_wr),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .last_grant (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: its write port is ignored while reset is held.
  always @(posedge clk) begin
    if (rst && rf_wr) mem[rf_rd] <= rf_wdata;
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        av;
    logic [3:0]  ard;
    logic [15:0] ad;
    logic        bv;
    logic [3:0]  brd;
    logic [15:0] bd;
    logic        e_ar;
    logic        e_br;
    logic        e_wr;
    logic [3:0]  e_rd;
    logic [15:0] e_wd;
    logic        e_last;
  } vec_t;

  localparam int NV = 27;
  vec_t vec [NV];

  function automatic vec_t mk(input logic r, input logic s,
                              input logic av, input logic [3:0] ard, input logic [15:0] ad,
                              input logic bv, input logic [3:0] brd, input logic [15:0] bd,
                              input logic ear, input logic ebr, input logic ewr,
                              input logic [3:0] erd, input logic [15:0] ewd, input logic elast);
    vec_t v;
    v.rst = r; v.stall = s; v.av = av; v.ard = ard; v.ad = ad;
    v.bv = bv; v.brd = brd; v.bd = bd; v.e_ar = ear; v.e_br = ebr;
    v.e_wr = ewr; v.e_rd = erd; v.e_wd = ewd; v.e_last = elast;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    logic exp_b;
    int   na;
    int   nb;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    rst = 1'b0; wb_stall = 1'b0;
    a_valid = 1'b1; a_rd = 4'd1; a_data = 16'h0101;
    b_valid = 1'b1; b_rd = 4'd2; b_data = 16'h0202;

    //            rst   stl  av   ard   ad        bv   brd    bd        ar   br   wr   rd     wd        last
    vec[0]  = mk(1'b0, 1'b0, 1'b1, 4'd1, 16'h0101, 1'b1, 4'd2,  16'h0202, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    vec[1]  = mk(1'b0, 1'b0, 1'b1, 4'd1, 16'h0101, 1'b1, 4'd2,  16'h0202, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    vec[2]  = mk(1'b0, 1'b0, 1'b1, 4'd1, 16'h0101, 1'b1, 4'd2,  16'h0202, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    vec[3]  = mk(1'b1, 1'b0, 1'b1, 4'd1, 16'h0101, 1'b1, 4'd2,  16'h0202, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    vec[4]  = mk(1'b1, 1'b0, 1'b1, 4'd1, 16'h0101, 1'b1, 4'd2,  16'h0202, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0101, 1'b0);
    vec[5]  = mk(1'b1, 1'b0, 1'b1, 4'd1, 16'h0101, 1'b1, 4'd2,  16'h0202, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0202, 1'b1);
    vec[6]  = mk(1'b1, 1'b0, 1'b1, 4'd1, 16'h0101, 1'b1, 4'd2,  16'h0202, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0101, 1'b0);
    vec[7]  = mk(1'b1, 1'b0, 1'b1, 4'd1, 16'h0101, 1'b1, 4'd2,  16'h0202, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0202, 1'b1);
    vec[8]  = mk(1'b1, 1'b0, 1'b1, 4'd1, 16'h0101, 1'b1, 4'd2,  16'h0202, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0101, 1'b0);
    vec[9]  = mk(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 4'd2, 16'h0202, 1'b1);
    vec[10] = mk(1'b1, 1'b0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0202, 1'b1);
    vec[11] = mk(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 4'd3, 16'h1234, 1'b0);
    vec[12] = mk(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 16'h1234, 1'b0);
    vec[13] = mk(1'b1, 1'b0, 1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5,  16'h5555, 1'b0, 1'b1, 1'b0, 4'd3, 16'h1234, 1'b0);
    vec[14] = mk(1'b1, 1'b0, 1'b1, 4'd5, 16'hAAAA, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 4'd5, 16'h5555, 1'b1);
    vec[15] = mk(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 4'd5, 16'hAAAA, 1'b0);
    vec[16] = mk(1'b1, 1'b0, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd7,  16'h7777, 1'b0, 1'b1, 1'b0, 4'd5, 16'hAAAA, 1'b0);
    vec[17] = mk(1'b1, 1'b1, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd7,  16'h7777, 1'b0, 1'b0, 1'b1, 4'd7, 16'h7777, 1'b1);
    vec[18] = mk(1'b1, 1'b1, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd7,  16'h7777, 1'b0, 1'b0, 1'b0, 4'd7, 16'h7777, 1'b1);
    vec[19] = mk(1'b1, 1'b1, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd7,  16'h7777, 1'b0, 1'b0, 1'b0, 4'd7, 16'h7777, 1'b1);
    vec[20] = mk(1'b1, 1'b1, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd7,  16'h7777, 1'b0, 1'b0, 1'b0, 4'd7, 16'h7777, 1'b1);
    vec[21] = mk(1'b1, 1'b0, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd7,  16'h7777, 1'b1, 1'b0, 1'b0, 4'd7, 16'h7777, 1'b1);
    vec[22] = mk(1'b1, 1'b0, 1'b1, 4'd8, 16'h8888, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 4'd6, 16'h6666, 1'b0);
    vec[23] = mk(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 4'd8, 16'h8888, 1'b0);
    vec[24] = mk(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    vec[25] = mk(1'b1, 1'b0, 1'b1, 4'd9, 16'h9999, 1'b1, 4'd10, 16'hABCD, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    vec[26] = mk(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 4'd9, 16'h9999, 1'b0);

    // Inputs change on the falling edge; checks land 1 ns later, mid-cycle.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vec[i].rst; wb_stall = vec[i].stall;
      a_valid = vec[i].av; a_rd = vec[i].ard; a_data = vec[i].ad;
      b_valid = vec[i].bv; b_rd = vec[i].brd; b_data = vec[i].bd;
      #1;
      check($sformatf("v%0d a_ready", i), {15'd0, a_ready}, {15'd0, vec[i].e_ar});
      check($sformatf("v%0d b_ready", i), {15'd0, b_ready}, {15'd0, vec[i].e_br});
      check($sformatf("v%0d rf_wr", i), {15'd0, rf_wr}, {15'd0, vec[i].e_wr});
      check($sformatf("v%0d rf_rd", i), {12'd0, rf_rd}, {12'd0, vec[i].e_rd});
      check($sformatf("v%0d rf_wdata", i), rf_wdata, vec[i].e_wd);
      check($sformatf("v%0d last_grant", i), {15'd0, last_grant}, {15'd0, vec[i].e_last});
    end

    // Register-file contents after the table: collision loser last, reset dropped the write.
    @(negedge clk);
    check("mem[3]", mem[3], 16'h1234);
    check("mem[5] collision", mem[5], 16'hAAAA);
    check("mem[6]", mem[6], 16'h6666);
    check("mem[7]", mem[7], 16'h7777);
    check("mem[8] dropped by reset", mem[8], 16'h0000);
    check("mem[9]", mem[9], 16'h9999);
    check("mem[10] not granted", mem[10], 16'h0000);

    // Continuous contention: A won last, so grants must go B, A, B, A, ...
    a_valid = 1'b1; a_rd = 4'd11; a_data = 16'h0B0B;
    b_valid = 1'b1; b_rd = 4'd12; b_data = 16'h0C0C;
    exp_b = 1'b1;
    na = 0;
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("alt%0d a_ready", k), {15'd0, a_ready}, {15'd0, ~exp_b});
      check($sformatf("alt%0d b_ready", k), {15'd0, b_ready}, {15'd0, exp_b});
      if (a_ready) na++;
      if (b_ready) nb++;
      exp_b = ~exp_b;
      @(negedge clk);
    end
    check("alt grants to A", na[15:0], 16'd5);
    check("alt grants to B", nb[15:0], 16'd5);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    #1;
    check("alt final rf_rd", {12'd0, rf_rd}, 16'd11);
    check("mem[12]", mem[12], 16'h0C0C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the 16-entry × 16-bit register file. It shares the file's single write port (Rd / RW / wr) between two requesters: requester A (ALU write-back) and requester B (load-unit write-back). It uses round-robin grant, valid/ready handshakes, a global stall, and a registered output stage that drives the register file directly.

## Interface
Parameters:
- DW, 16, write data width
- AW, 4, register address width (2^AW registers)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset)
- wb_stall  in  1  pipeline stall; 1 blocks all grants
- a_valid  in  1  requester A has a write pending
- a_rd  in  AW  requester A destination register
- a_data  in  DW  requester A write data
- a_ready  out  1  A accepted this cycle (combinational)
- b_valid  in  1  requester B has a write pending
- b_rd  in  AW  requester B destination register
- b_data  in  DW  requester B write data
- b_ready  out  1  B accepted this cycle (combinational)
- rf_wr  out  1  register-file write enable (registered)
- rf_rd  out  AW  register-file write address (registered)
- rf_wdata  out  DW  register-file write data (registered)
- last_grant  out  1  0 = A won last grant, 1 = B (registered)

## Operation
- Handshake: a transfer occurs when x_valid && x_ready at a rising edge. Requesters hold rd/data stable while valid and not ready.
- Grant logic (combinational), when wb_stall=0:
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the requester that did not win the most recent grant gets ready=1.
  - At most one ready is ever 1.
- When wb_stall=1: a_ready = b_ready = 0.
- ready may depend on valid. valid must not depend on ready.
- Round-robin pointer (last_grant): two states, LAST_A(0) and LAST_B(1).
  - Moves to the granted requester on each transfer.
  - Unchanged in cycles with no transfer.
- Output stage:
  - On a transfer: rf_wr←1, and rf_rd/rf_wdata←winner's rd/data.
  - With no transfer: rf_wr←0, and rf_rd/rf_wdata hold their previous values.
- Same-rd collision (both valid, same rd): granted strictly by round-robin. The loser writes one cycle later and its value is the final content. Ordering between A and B is the requesters' responsibility.
- Register 0 is not special; writes to rd=0 pass through unchanged.

## Timing
- Reset values: rf_wr=0, rf_rd=0, rf_wdata=0, last_grant=1 (A preferred on the first contention). a_ready/b_ready follow the combinational rule from reset state.
- While rst=0, a_ready=b_ready=0.
- Latency: transfer at edge N → rf_wr=1 during cycle N..N+1 → register file updates at edge N+1.
- Throughput: one write per cycle. With both requesters continuously valid, grants alternate A, B, A, B…
- Stall asserted in the cycle after a transfer: the already-registered write still completes (rf_wr=1 that cycle). The next rf_wr is 0.
- Stall deasserts: grants resume the same cycle. The pointer is unchanged across the stall.
- Reset mid-operation: any registered, uncommitted write is dropped (rf_wr=0 after the reset edge). The pointer returns to 1.
- A requester that drops valid before being granted loses nothing. No state is kept for it.

## Structure
- Shared package (rf_pkg): DW, AW, requester ID constants REQ_A=0 and REQ_B=1.
- One natural sub-module: rr_arb2, the two-input round-robin grant with a pointer register. The output register and stall gating stay in the top.
- Top instantiates rr_arb2 and drives the Register_File write port from the rf_* outputs.

## Test plan
- Reset: hold rst=0 for 3 cycles with a_valid=b_valid=1 → a_ready=b_ready=0, rf_wr=0, last_grant=1. Release → first grant goes to A.
- Single requester: A writes rd=3, data=0x1234 → rf_wr=1, rf_rd=3, rf_wdata=0x1234 exactly one cycle after the transfer, then rf_wr=0.
- Contention: both valid for 6 cycles (A: rd=1, B: rd=2) → grants A,B,A,B,A,B. rf_rd sequence is 1,2,1,2,1,2, each delayed one cycle.
- Collision: A rd=5 data=0xAAAA and B rd=5 data=0x5555 together, pointer=LAST_A → B written first, then A. Register 5 ends at 0xAAAA.
- Stall: wb_stall=1 for 4 cycles with both valid → no readies. rf_wr=0 from the second stalled cycle on, and the pointer holds. Release → grant goes to the requester opposite last_grant.
- Reset mid-stream: assert rst=0 in the cycle after a transfer → rf_wr=0 after the reset edge, and the register file is not written.
